// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings,
// register-file constants, the control bundle and the load-use detector.
package hazard_ctrl_pkg;

   localparam int REG_W = 5;

   localparam logic       ST_RUN    = 1'b0;
   localparam logic       ST_FREEZE = 1'b1;
   localparam logic [4:0] REG_ZERO  = 5'd0;

   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic if_id_flush;
      logic id_ex_bubble;
      logic pipe_freeze;
   } hazard_ctrl_t;

   // Normal advance: PC and IF/ID update, nothing killed or held.
   localparam hazard_ctrl_t CTRL_RUN    = '{pc_write: 1'b1, if_id_write: 1'b1,
                                            if_id_flush: 1'b0, id_ex_bubble: 1'b0,
                                            pipe_freeze: 1'b0};
   localparam hazard_ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0,
                                            if_id_flush: 1'b0, id_ex_bubble: 1'b0,
                                            pipe_freeze: 1'b1};
   localparam hazard_ctrl_t CTRL_BUBBLE = '{pc_write: 1'b0, if_id_write: 1'b0,
                                            if_id_flush: 1'b0, id_ex_bubble: 1'b1,
                                            pipe_freeze: 1'b0};
   localparam hazard_ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, if_id_write: 1'b1,
                                            if_id_flush: 1'b1, id_ex_bubble: 1'b0,
                                            pipe_freeze: 1'b0};

   // A load in EX feeding a source of the instruction in ID cannot be forwarded
   // in time; $zero is never a real dependency.
   function automatic logic is_load_use(
      input logic             mem_read,
      input logic [REG_W-1:0] ex_rt,
      input logic [REG_W-1:0] id_rs,
      input logic [REG_W-1:0] id_rt,
      input logic             uses_rt
   );
      return mem_read && (ex_rt != REG_ZERO) &&
             ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
   endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard controller's stall statistics.
// Holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign q = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use bubbles, ID-stage
// branch flushes, cache-miss freezes with a pending redirect, and stall counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       IfIdRs,
   input  logic [4:0]       IfIdRt,
   input  logic             IfIdUsesRt,
   input  logic             IdExMemRead,
   input  logic [4:0]       IdExRt,
   input  logic             IdBranchTaken,
   input  logic             ICacheStall,
   input  logic             DCacheStall,
   output logic             PcWrite,
   output logic             IfIdWrite,
   output logic             IfIdFlush,
   output logic             IdExBubble,
   output logic             PipeFreeze,
   output logic [CNT_W-1:0] BubbleCnt,
   output logic [CNT_W-1:0] FreezeCnt,
   output logic [CNT_W-1:0] FlushCnt
);

   logic         st_q;
   logic         st_d;
   logic         flush_pend_q;
   logic         flush_pend_d;
   logic         mem_stall;
   logic         load_use;
   hazard_ctrl_t ctrl;

   assign mem_stall = ICacheStall | DCacheStall;
   assign load_use  = is_load_use(IdExMemRead, IdExRt, IfIdRs, IfIdRt, IfIdUsesRt);

   // Priority: cache miss > load-use > branch redirect. A branch seen while
   // frozen is remembered and replayed as a flush on the release cycle.
   always_comb begin
      ctrl         = CTRL_RUN;
      st_d         = st_q;
      flush_pend_d = flush_pend_q;
      if (mem_stall) begin
         ctrl         = CTRL_FREEZE;
         st_d         = ST_FREEZE;
         flush_pend_d = (st_q == ST_FREEZE) ? (flush_pend_q | IdBranchTaken) : IdBranchTaken;
      end else begin
         st_d         = ST_RUN;
         flush_pend_d = 1'b0;
         if (load_use) begin
            ctrl = CTRL_BUBBLE;
         end else if (IdBranchTaken || ((st_q == ST_FREEZE) && flush_pend_q)) begin
            ctrl = CTRL_FLUSH;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q         <= ST_RUN;
         flush_pend_q <= 1'b0;
      end else begin
         st_q         <= st_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   assign PcWrite    = ctrl.pc_write;
   assign IfIdWrite  = ctrl.if_id_write;
   assign IfIdFlush  = ctrl.if_id_flush;
   assign IdExBubble = ctrl.id_ex_bubble;
   assign PipeFreeze = ctrl.pipe_freeze;

   sat_counter #(.W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (ctrl.id_ex_bubble),
      .q     (BubbleCnt)
   );

   sat_counter #(.W(CNT_W)) u_freeze_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (ctrl.pipe_freeze),
      .q     (FreezeCnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (ctrl.if_id_flush),
      .q     (FlushCnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed multi-cycle
// sequences and random traffic against a cycle-level reference model.
module tb_hazard_ctrl;

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       ur;
      logic       mr;
      logic [4:0] ert;
      logic       br;
      logic       ic;
      logic       dc;
   } in_t;

   typedef struct {
      in_t        in;
      logic [4:0] exp;   // {PcWrite, IfIdWrite, IfIdFlush, IdExBubble, PipeFreeze}
   } vec_t;

   localparam logic [4:0] O_RUN    = 5'b11000;
   localparam logic [4:0] O_FLUSH  = 5'b11100;
   localparam logic [4:0] O_BUBBLE = 5'b00010;
   localparam logic [4:0] O_FREEZE = 5'b00001;

   logic clk = 1'b0;
   logic rst_n;
   logic [4:0] IfIdRs, IfIdRt, IdExRt;
   logic IfIdUsesRt, IdExMemRead, IdBranchTaken, ICacheStall, DCacheStall;

   logic PcWrite, IfIdWrite, IfIdFlush, IdExBubble, PipeFreeze;
   logic [31:0] BubbleCnt, FreezeCnt, FlushCnt;
   logic s_PcWrite, s_IfIdWrite, s_IfIdFlush, s_IdExBubble, s_PipeFreeze;
   logic [3:0] s_BubbleCnt, s_FreezeCnt, s_FlushCnt;

   int checks = 0;
   int errors = 0;

   // Reference model: a "frozen" flag, a remembered redirect and plain event counts.
   bit m_frz, m_pend;
   longint unsigned m_bub, m_frzc, m_fl;

   always #5 clk = ~clk;

   hazard_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .IfIdRs(IfIdRs), .IfIdRt(IfIdRt), .IfIdUsesRt(IfIdUsesRt),
      .IdExMemRead(IdExMemRead), .IdExRt(IdExRt), .IdBranchTaken(IdBranchTaken),
      .ICacheStall(ICacheStall), .DCacheStall(DCacheStall), .PcWrite(PcWrite),
      .IfIdWrite(IfIdWrite), .IfIdFlush(IfIdFlush), .IdExBubble(IdExBubble),
      .PipeFreeze(PipeFreeze), .BubbleCnt(BubbleCnt), .FreezeCnt(FreezeCnt), .FlushCnt(FlushCnt)
   );

   hazard_ctrl #(.CNT_W(4)) dut_s (
      .clk(clk), .rst_n(rst_n), .IfIdRs(IfIdRs), .IfIdRt(IfIdRt), .IfIdUsesRt(IfIdUsesRt),
      .IdExMemRead(IdExMemRead), .IdExRt(IdExRt), .IdBranchTaken(IdBranchTaken),
      .ICacheStall(ICacheStall), .DCacheStall(DCacheStall), .PcWrite(s_PcWrite),
      .IfIdWrite(s_IfIdWrite), .IfIdFlush(s_IfIdFlush), .IdExBubble(s_IdExBubble),
      .PipeFreeze(s_PipeFreeze), .BubbleCnt(s_BubbleCnt), .FreezeCnt(s_FreezeCnt),
      .FlushCnt(s_FlushCnt)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic in_t mk(input int rs, input int rt, input bit ur, input bit mr,
                              input int ert, input bit br, input bit ic, input bit dc);
      in_t v;
      v.rs = 5'(rs); v.rt = 5'(rt); v.ur = ur; v.mr = mr;
      v.ert = 5'(ert); v.br = br; v.ic = ic; v.dc = dc;
      return v;
   endfunction

   function automatic longint unsigned sat(input longint unsigned c, input int w);
      longint unsigned mx = (64'd1 << w) - 64'd1;
      return (c > mx) ? mx : c;
   endfunction

   function automatic logic [4:0] model_out(input in_t v);
      bit stall = v.ic || v.dc;
      bit lu = v.mr && (v.ert != 0) && ((v.ert == v.rs) || (v.ur && (v.ert == v.rt)));
      if (stall) return O_FREEZE;
      if (lu) return O_BUBBLE;
      if (v.br || m_pend) return O_FLUSH;
      return O_RUN;
   endfunction

   function automatic void model_step(input in_t v, input logic [4:0] o);
      if (o[1]) m_bub++;
      if (o[2]) m_fl++;
      if (o[0]) m_frzc++;
      if (v.ic || v.dc) begin
         m_pend = m_pend || v.br;
         m_frz  = 1'b1;
      end else begin
         m_pend = 1'b0;
         m_frz  = 1'b0;
      end
   endfunction

   function automatic void model_reset();
      m_frz = 0; m_pend = 0; m_bub = 0; m_frzc = 0; m_fl = 0;
   endfunction

   task automatic apply(input in_t v);
      IfIdRs = v.rs; IfIdRt = v.rt; IfIdUsesRt = v.ur; IdExMemRead = v.mr;
      IdExRt = v.ert; IdBranchTaken = v.br; ICacheStall = v.ic; DCacheStall = v.dc;
   endtask

   task automatic check_counters();
      check("BubbleCnt", 64'(BubbleCnt), sat(m_bub, 32));
      check("FreezeCnt", 64'(FreezeCnt), sat(m_frzc, 32));
      check("FlushCnt", 64'(FlushCnt), sat(m_fl, 32));
      check("BubbleCnt_w4", 64'(s_BubbleCnt), sat(m_bub, 4));
      check("FreezeCnt_w4", 64'(s_FreezeCnt), sat(m_frzc, 4));
      check("FlushCnt_w4", 64'(s_FlushCnt), sat(m_fl, 4));
   endtask

   // One pipeline cycle: drive, compare at the falling edge, advance the model.
   task automatic cycle(input in_t v, input bit use_exp, input logic [4:0] exp);
      logic [4:0] m;
      apply(v);
      @(negedge clk);
      m = model_out(v);
      check("outs_model", {PcWrite, IfIdWrite, IfIdFlush, IdExBubble, PipeFreeze}, m);
      check("outs_w4", {s_PcWrite, s_IfIdWrite, s_IfIdFlush, s_IdExBubble, s_PipeFreeze}, m);
      if (use_exp)
         check("outs_table", {PcWrite, IfIdWrite, IfIdFlush, IdExBubble, PipeFreeze}, exp);
      check_counters();
      @(posedge clk);
      model_step(v, m);
      #1;
   endtask

   task automatic do_reset();
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
      rst_n = 1'b0;
      model_reset();
      #1;
      check("reset_outs", {PcWrite, IfIdWrite, IfIdFlush, IdExBubble, PipeFreeze}, O_RUN);
      check_counters();
      #1;
      rst_n = 1'b1;
   endtask

   vec_t tbl[9];
   in_t  idle;
   in_t  rv;

   initial begin
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
      tbl[0] = '{mk(0, 0, 0, 0, 0, 0, 0, 0), O_RUN};     // idle
      tbl[1] = '{mk(8, 0, 0, 1, 8, 0, 0, 0), O_BUBBLE};  // load-use on rs
      tbl[2] = '{mk(3, 8, 0, 1, 8, 0, 0, 0), O_RUN};     // rt match but rt not read
      tbl[3] = '{mk(3, 8, 1, 1, 8, 0, 0, 0), O_BUBBLE};  // load-use on rt
      tbl[4] = '{mk(0, 0, 1, 1, 0, 0, 0, 0), O_RUN};     // $zero never stalls
      tbl[5] = '{mk(0, 0, 0, 0, 0, 1, 0, 0), O_FLUSH};   // branch alone
      tbl[6] = '{mk(8, 0, 0, 1, 8, 1, 0, 0), O_BUBBLE};  // load-use beats branch
      tbl[7] = '{mk(8, 0, 0, 0, 8, 0, 0, 0), O_RUN};     // not a load
      tbl[8] = '{mk(0, 0, 0, 1, 0, 1, 0, 0), O_FLUSH};   // $zero load + branch

      apply(idle);
      rst_n = 1'b0;
      model_reset();
      #2;
      check("por_outs", {PcWrite, IfIdWrite, IfIdFlush, IdExBubble, PipeFreeze}, O_RUN);
      check("por_cnt", 64'(BubbleCnt) | 64'(FreezeCnt) | 64'(FlushCnt), 64'd0);
      #10;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 9; i++) cycle(tbl[i].in, 1'b1, tbl[i].exp);
      check("tbl_bubbles", 64'(BubbleCnt), 64'd3);
      check("tbl_flushes", 64'(FlushCnt), 64'd2);

      // Branch during a 4-cycle I-cache miss: flush only on release.
      do_reset();
      for (int i = 0; i < 4; i++) cycle(mk(0, 0, 0, 0, 0, i == 1, 1, 0), 1'b1, O_FREEZE);
      cycle(idle, 1'b1, O_FLUSH);
      check("freeze4_cnt", 64'(FreezeCnt), 64'd4);
      check("freeze4_flush", 64'(FlushCnt), 64'd1);

      // D-cache miss beats load-use and branch; on release load-use suppresses flush.
      do_reset();
      cycle(mk(8, 0, 0, 1, 8, 1, 0, 1), 1'b1, O_FREEZE);
      cycle(mk(8, 0, 0, 1, 8, 0, 0, 0), 1'b1, O_BUBBLE);
      cycle(idle, 1'b1, O_RUN);
      check("prio_flush", 64'(FlushCnt), 64'd0);
      check("prio_bubble", 64'(BubbleCnt), 64'd1);

      // Reset mid-freeze drops the pending redirect.
      do_reset();
      cycle(mk(0, 0, 0, 0, 0, 1, 1, 1), 1'b1, O_FREEZE);
      cycle(mk(0, 0, 0, 0, 0, 0, 1, 0), 1'b1, O_FREEZE);
      do_reset();
      cycle(idle, 1'b1, O_RUN);

      // Saturation: 20 freeze cycles on a 4-bit counter hold at 15.
      do_reset();
      for (int i = 0; i < 20; i++) cycle(mk(0, 0, 0, 0, 0, 0, i[0], 1), 1'b1, O_FREEZE);
      cycle(idle, 1'b1, O_RUN);
      check("sat_w4", 64'(s_FreezeCnt), 64'd15);
      check("sat_w32", 64'(FreezeCnt), 64'd20);

      // Random traffic over a small register set to provoke frequent matches.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         rv = mk($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 5) == 0);
         cycle(rv, 1'b0, 5'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
